uart_rx_fifo: RTL and testbench

- Receive-side partner of the CPU's UART read port.
- Deserialises an 8N1 serial line into bytes and buffers them in a show-ahead FIFO.
- The CPU consumes bytes through uart_rx_data / empty / uart_rd_en.
- Sits between the board RX pin and the cpu top; the CPU-side handshake is the same one the CPU bench currently stubs with empty=1.

---
 rtl/uart_rx_fifo.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead (first-word fall-through) FIFO.
// The CPU reads through uart_rx_data / empty / uart_rd_en.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit after the data bits.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle, waiting for rxd_s to go low
// S_START  | timing to the middle of the start bit, rejecting glitches
// S_DATA   | sampling 8 data bits LSB-first at mid-bit
// S_PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// S_STOP   | sampling the stop bit; the byte is pushed or dropped here
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    output logic [7:0]            uart_rx_data,
    output logic                  empty,
    input  logic                  uart_rd_en,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    output logic                  frame_err,
    output logic                  parity_err,
    input  logic                  err_clr
);

    localparam int CYC_W = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CYC_W-1:0]    CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [CYC_W-1:0]    CYC_HALF = CYC_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CYC_W-1:0]    CYC_ONE  = CYC_W'(1);
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic                  rxd_m, rxd_s;
    state_t                state, state_n;
    logic [CYC_W-1:0]      cyc, cyc_n;
    logic [2:0]            idx, idx_n;
    logic [7:0]            shreg, shreg_n;
    logic                  push, frame_set;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad, par_bad_n, parity_set;
`endif

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic                  full, do_pop, do_push, ovr_set;

    // Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // Receiver state register and bit timing counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cyc   <= '0;
            idx   <= '0;
            shreg <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cyc   <= cyc_n;
            idx   <= idx_n;
            shreg <= shreg_n;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_n;
`endif
        end
    end

    // Next-state logic; STOP returns to IDLE mid stop bit so back-to-back frames are caught.
    always_comb begin
        state_n   = state;
        cyc_n     = cyc;
        idx_n     = idx;
        shreg_n   = shreg;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n  = par_bad;
        parity_set = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_n = S_START;
                    cyc_n   = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_n = 1'b0;
`endif
                end
            end
            S_START: begin
                if (cyc == CYC_HALF) begin
                    cyc_n   = '0;
                    idx_n   = '0;
                    state_n = rxd_s ? S_IDLE : S_DATA;
                end else begin
                    cyc_n = cyc + CYC_ONE;
                end
            end
            S_DATA: begin
                if (cyc == CYC_LAST) begin
                    cyc_n   = '0;
                    shreg_n = {rxd_s, shreg[7:1]};
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cyc_n = cyc + CYC_ONE;
                end
            end
            S_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (cyc == CYC_LAST) begin
                    cyc_n   = '0;
                    state_n = S_STOP;
                    if (rxd_s != ^shreg) begin
                        par_bad_n  = 1'b1;
                        parity_set = 1'b1;
                    end
                end else begin
                    cyc_n = cyc + CYC_ONE;
                end
`else
                state_n = S_IDLE;
`endif
            end
            S_STOP: begin
                if (cyc == CYC_LAST) begin
                    cyc_n   = '0;
                    state_n = S_IDLE;
                    if (!rxd_s) begin
                        frame_set = 1'b1;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        push = !par_bad;
`else
                        push = 1'b1;
`endif
                    end
                end else begin
                    cyc_n = cyc + CYC_ONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = uart_rd_en && !empty;
    assign do_push = push && (!full || do_pop);
    assign ovr_set = push && full && !do_pop;

    assign uart_rx_data = empty ? 8'h00 : mem[rptr];

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= shreg;
        end
    end

    // FIFO pointers and occupancy; a pop on an empty FIFO is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a set event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= ovr_set   | (overrun   & ~err_clr);
            frame_err <= frame_set | (frame_err & ~err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity error flag; set wins over clear.
    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= parity_set | (parity_err & ~err_clr);
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of the UART receiver FIFO at CLKS_PER_BIT=16, depth 4.
module tb_uart_rx_fifo;

    localparam int CPB = 16;
    localparam int DL  = 2;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic         clk = 1'b0;
    logic         rst, rxd, uart_rd_en, err_clr;
    logic [7:0]   uart_rx_data;
    logic         empty, overrun, frame_err, parity_err;
    logic [DL:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .rxd(rxd),
        .uart_rx_data(uart_rx_data), .empty(empty), .uart_rd_en(uart_rd_en),
        .count(count), .overrun(overrun), .frame_err(frame_err),
        .parity_err(parity_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] frame;
        frame = (PBITS != 0) ? {stop, par, d, 1'b0} : {1'b1, stop, d, 1'b0};
        for (int i = 0; i < 10 + PBITS; i++) drive_bit(frame[i]);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, ^d, 1'b1);
    endtask

    task automatic pulse_rd();
        @(posedge clk); #1 uart_rd_en = 1'b1;
        @(posedge clk); #1 uart_rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rxd = 1'b1; uart_rd_en = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({empty, count, overrun, frame_err, parity_err, uart_rx_data} !== {1'b1, 3'd0, 3'b000, 8'h00}) begin
            n_err++;
            $display("FAIL reset_state got e=%b c=%0d o=%b f=%b p=%b d=%h exp e=1 c=0 flags=0 d=00",
                     empty, count, overrun, frame_err, parity_err, uart_rx_data);
        end
    endtask

    task automatic test_single();
        int n;
        n = 0;
        fork
            begin
                @(posedge clk); #1;
                send_byte(8'hA5);
            end
            begin
                @(posedge clk);
                while (empty && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                n_cmp++;
                if (n !== 156 + 16 * PBITS) begin
                    n_err++;
                    $display("FAIL a5_latency got %0d cycles exp %0d", n, 156 + 16 * PBITS);
                end
                n_cmp++;
                if ({uart_rx_data, count} !== {8'hA5, 3'd1}) begin
                    n_err++;
                    $display("FAIL a5_data got d=%h c=%0d exp d=a5 c=1", uart_rx_data, count);
                end
            end
        join
        pulse_rd();
        @(negedge clk);
        n_cmp++;
        if ({empty, count} !== {1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL a5_pop got e=%b c=%0d exp e=1 c=0", empty, count);
        end
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        @(negedge clk);
        n_cmp++;
        if ({empty, count, overrun} !== {1'b0, 3'd4, 1'b1}) begin
            n_err++;
            $display("FAIL ovr_fill got e=%b c=%0d o=%b exp e=0 c=4 o=1", empty, count, overrun);
        end
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (uart_rx_data !== 8'(i)) begin
                n_err++;
                $display("FAIL ovr_order got %h exp %h", uart_rx_data, 8'(i));
            end
            pulse_rd();
            @(negedge clk);
        end
        n_cmp++;
        if ({empty, count} !== {1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL ovr_drain got e=%b c=%0d exp e=1 c=0", empty, count);
        end
        pulse_clr();
        @(negedge clk);
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_clear got %b exp 0", overrun);
        end
    endtask

    task automatic test_glitch();
        idle(20);
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1 rxd = 1'b1;
        idle(40);
        @(negedge clk);
        n_cmp++;
        if ({count, overrun, frame_err, parity_err} !== {3'd0, 3'b000}) begin
            n_err++;
            $display("FAIL glitch got c=%0d o=%b f=%b p=%b exp all 0", count, overrun, frame_err, parity_err);
        end
        @(posedge clk); #1;
        send_byte(8'hC3);
        @(negedge clk);
        n_cmp++;
        if ({uart_rx_data, count} !== {8'hC3, 3'd1}) begin
            n_err++;
            $display("FAIL glitch_next got d=%h c=%0d exp d=c3 c=1", uart_rx_data, count);
        end
        pulse_rd();
    endtask

    task automatic test_frame_err();
        @(posedge clk); #1;
        send_frame(8'h3C, ^8'h3C, 1'b0);
        idle(32);
        @(negedge clk);
        n_cmp++;
        if ({frame_err, count} !== {1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL ferr_set got f=%b c=%0d exp f=1 c=0", frame_err, count);
        end
        @(posedge clk); #1;
        send_byte(8'h7E);
        @(negedge clk);
        n_cmp++;
        if ({uart_rx_data, count, frame_err} !== {8'h7E, 3'd1, 1'b1}) begin
            n_err++;
            $display("FAIL ferr_next got d=%h c=%0d f=%b exp d=7e c=1 f=1", uart_rx_data, count, frame_err);
        end
        pulse_clr();
        pulse_rd();
        @(negedge clk);
        n_cmp++;
        if ({frame_err, count} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL ferr_clear got f=%b c=%0d exp f=0 c=0", frame_err, count);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_q [4];
        exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        @(negedge clk);
        n_cmp++;
        if ({count, overrun} !== {3'd4, 1'b0}) begin
            n_err++;
            $display("FAIL full_fill got c=%0d o=%b exp c=4 o=0", count, overrun);
        end
        fork
            begin
                @(posedge clk); #1;
                send_byte(8'h55);
            end
            begin
                @(posedge clk);
                repeat (154 + 16 * PBITS) @(posedge clk);
                #1 uart_rd_en = 1'b1;
                @(posedge clk);
                #1 uart_rd_en = 1'b0;
            end
        join
        @(negedge clk);
        n_cmp++;
        if ({count, overrun} !== {3'd4, 1'b0}) begin
            n_err++;
            $display("FAIL full_pushpop got c=%0d o=%b exp c=4 o=0", count, overrun);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (uart_rx_data !== exp_q[i]) begin
                n_err++;
                $display("FAIL full_order got %h exp %h", uart_rx_data, exp_q[i]);
            end
            pulse_rd();
            @(negedge clk);
        end
        pulse_rd();
        @(negedge clk);
        n_cmp++;
        if ({empty, count, uart_rx_data} !== {1'b1, 3'd0, 8'h00}) begin
            n_err++;
            $display("FAIL empty_rd got e=%b c=%0d d=%h exp e=1 c=0 d=00", empty, count, uart_rx_data);
        end
        @(posedge clk); #1;
        send_byte(8'h66);
        @(negedge clk);
        n_cmp++;
        if ({uart_rx_data, count} !== {8'h66, 3'd1}) begin
            n_err++;
            $display("FAIL empty_rd_next got d=%h c=%0d exp d=66 c=1", uart_rx_data, count);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'hC6;
        @(posedge clk); #1;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rxd = d[4];
        repeat (8) @(posedge clk);
        #1 rst = 1'b1; rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(32);
        @(negedge clk);
        n_cmp++;
        if ({empty, count} !== {1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL rst_mid got e=%b c=%0d exp e=1 c=0", empty, count);
        end
        @(posedge clk); #1;
        send_byte(8'h55);
        @(negedge clk);
        n_cmp++;
        if ({uart_rx_data, count, overrun, frame_err, parity_err} !== {8'h55, 3'd1, 3'b000}) begin
            n_err++;
            $display("FAIL rst_next got d=%h c=%0d o=%b f=%b p=%b exp d=55 c=1 flags=0",
                     uart_rx_data, count, overrun, frame_err, parity_err);
        end
        pulse_rd();
`ifdef UART_RX_PARITY_EN
        @(posedge clk); #1;
        send_frame(8'h55, 1'b1, 1'b1);
        idle(4);
        @(negedge clk);
        n_cmp++;
        if ({parity_err, frame_err, count} !== {1'b1, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL parity got p=%b f=%b c=%0d exp p=1 f=0 c=0", parity_err, frame_err, count);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_glitch();
        test_frame_err();
        test_full_pop();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
